id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand preparation, directly upstream of the 32-bit ALU.
- Captures decoded instruction fields and register-file read data each cycle.
- Drives the ALU's Signal, DataA and DataB: ALU control decode, forwarding muxes and immediate/shamt select.
- Carries memory/writeback control and StoreData forward to the EX/MEM register.

---
 rtl/id_ex_stage_pkg.sv | 30 +++
 rtl/id_ex_stage_alu_control.sv | 35 +++
 rtl/id_ex_stage.sv | 176 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU Signal codes, ALUOp
// encodings, default widths and the supported R-type funct check.
package id_ex_stage_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned RADDR_DEF = 5;

  // ALU Signal codes (equal to the MIPS funct values they implement)
  localparam logic [5:0] SIG_AND = 6'b100100;
  localparam logic [5:0] SIG_OR  = 6'b100101;
  localparam logic [5:0] SIG_ADD = 6'b100000;
  localparam logic [5:0] SIG_SUB = 6'b100010;
  localparam logic [5:0] SIG_SLT = 6'b101010;
  localparam logic [5:0] SIG_SRL = 6'b000010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  function automatic logic funct_supported(input logic [5:0] funct);
    case (funct)
      SIG_AND, SIG_OR, SIG_ADD, SIG_SUB, SIG_SLT, SIG_SRL: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_control.sv
// ALU control decode: ALUOp/funct -> ALU Signal, plus illegal-funct flag.
// Purely combinational.
// Ports:
//   alu_op  in  2  ALUOp encoding
//   funct   in  6  instruction funct field
//   signal  out 6  ALU operation code
//   illegal out 1  R-type funct outside the supported set (Signal forced to ADD)
module id_ex_stage_alu_control
  import id_ex_stage_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [5:0] funct,
  output logic [5:0] signal,
  output logic       illegal
);

  always_comb begin
    signal  = SIG_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: signal = SIG_ADD;
      ALUOP_SUB: signal = SIG_SUB;
      ALUOP_OR:  signal = SIG_OR;
      ALUOP_RTYPE: begin
        if (funct_supported(funct)) begin
          signal = funct;
        end else begin
          illegal = 1'b1;
        end
      end
      default: signal = SIG_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX-stage operand preparation for the ALU.
// Optional feature macro: ID_EX_FORWARD_EN (EX/MEM and MEM/WB forwarding).
// Ports:
//   Clk, Reset (async, active-high), Stall, Flush
//   Id*        decoded fields and register read data from ID
//   ExMem*     EX/MEM forwarding source (write enable, rd, data)
//   MemWb*     MEM/WB forwarding source (write enable, rd, data)
//   Signal     ALU operation code
//   DataA/B    ALU operands
//   StoreData  forwarded rt value for stores
//   WriteReg   destination register (Rd or Rt)
//   RegWrite, MemRead, MemWrite, MemToReg  registered control
//   IllegalOp  registered R-type funct outside the supported set
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned RADDR = RADDR_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Flush,
  input  logic [WIDTH-1:0] IdRD1,
  input  logic [WIDTH-1:0] IdRD2,
  input  logic [WIDTH-1:0] IdImm,
  input  logic [RADDR-1:0] IdRs,
  input  logic [RADDR-1:0] IdRt,
  input  logic [RADDR-1:0] IdRd,
  input  logic [4:0]       IdShamt,
  input  logic [5:0]       IdFunct,
  input  logic [1:0]       IdALUOp,
  input  logic             IdALUSrc,
  input  logic             IdRegDst,
  input  logic             IdRegWrite,
  input  logic             IdMemRead,
  input  logic             IdMemWrite,
  input  logic             IdMemToReg,
  input  logic             ExMemRegWrite,
  input  logic [RADDR-1:0] ExMemRd,
  input  logic [WIDTH-1:0] ExMemData,
  input  logic             MemWbRegWrite,
  input  logic [RADDR-1:0] MemWbRd,
  input  logic [WIDTH-1:0] MemWbData,
  output logic [5:0]       Signal,
  output logic [WIDTH-1:0] DataA,
  output logic [WIDTH-1:0] DataB,
  output logic [WIDTH-1:0] StoreData,
  output logic [RADDR-1:0] WriteReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IllegalOp
);

  logic [WIDTH-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [RADDR-1:0] ex_rs, ex_rt, ex_rd;
  logic [4:0]       ex_shamt;
  logic [5:0]       ex_funct;
  alu_op_e          ex_alu_op;
  logic             ex_alu_src, ex_reg_dst;
  logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_shamt      <= '0;
      ex_funct      <= '0;
      ex_alu_op     <= ALUOP_ADD;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (Flush) begin
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_shamt      <= '0;
      ex_funct      <= '0;
      ex_alu_op     <= ALUOP_ADD;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
    end else if (!Stall) begin
      ex_rd1        <= IdRD1;
      ex_rd2        <= IdRD2;
      ex_imm        <= IdImm;
      ex_rs         <= IdRs;
      ex_rt         <= IdRt;
      ex_rd         <= IdRd;
      ex_shamt      <= IdShamt;
      ex_funct      <= IdFunct;
      ex_alu_op     <= alu_op_e'(IdALUOp);
      ex_alu_src    <= IdALUSrc;
      ex_reg_dst    <= IdRegDst;
      ex_reg_write  <= IdRegWrite;
      ex_mem_read   <= IdMemRead;
      ex_mem_write  <= IdMemWrite;
      ex_mem_to_reg <= IdMemToReg;
    end
  end

  // Decoding from the registered ALUOp/funct makes the illegal flag a pure
  // function of ID/EX state, so it behaves exactly like a latched flag
  // (cleared by reset/flush, held by stall) without a separate register.
  id_ex_stage_alu_control u_alu_control (
    .alu_op  (ex_alu_op),
    .funct   (ex_funct),
    .signal  (Signal),
    .illegal (IllegalOp)
  );

  logic [WIDTH-1:0] fwd_a, fwd_b;

`ifdef ID_EX_FORWARD_EN
  // EX/MEM has priority over MEM/WB; $0 is never forwarded.
  always_comb begin
    fwd_a = ex_rd1;
    if (ExMemRegWrite && (ExMemRd != '0) && (ExMemRd == ex_rs)) begin
      fwd_a = ExMemData;
    end else if (MemWbRegWrite && (MemWbRd != '0) && (MemWbRd == ex_rs)) begin
      fwd_a = MemWbData;
    end
  end

  always_comb begin
    fwd_b = ex_rd2;
    if (ExMemRegWrite && (ExMemRd != '0) && (ExMemRd == ex_rt)) begin
      fwd_b = ExMemData;
    end else if (MemWbRegWrite && (MemWbRd != '0) && (MemWbRd == ex_rt)) begin
      fwd_b = MemWbData;
    end
  end
`else
  assign fwd_a = ex_rd1;
  assign fwd_b = ex_rd2;

  // Forwarding sources and rs are kept as ports/state but ignored here.
  logic unused_fwd;
  assign unused_fwd = ^{ExMemRegWrite, ExMemRd, ExMemData,
                        MemWbRegWrite, MemWbRd, MemWbData, ex_rs};
`endif

  // SRL shifts the rt value by shamt, so rt moves onto the A operand.
  always_comb begin
    if (Signal == SIG_SRL) begin
      DataA = fwd_b;
      DataB = WIDTH'(ex_shamt);
    end else begin
      DataA = fwd_a;
      DataB = ex_alu_src ? ex_imm : fwd_b;
    end
  end

  assign StoreData = fwd_b;
  assign WriteReg  = ex_reg_dst ? ex_rd : ex_rt;
  assign RegWrite  = ex_reg_write;
  assign MemRead   = ex_mem_read;
  assign MemWrite  = ex_mem_write;
  assign MemToReg  = ex_mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush;
  logic [31:0] IdRD1, IdRD2, IdImm;
  logic [4:0]  IdRs, IdRt, IdRd, IdShamt;
  logic [5:0]  IdFunct;
  logic [1:0]  IdALUOp;
  logic        IdALUSrc, IdRegDst, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemRd, MemWbRd;
  logic [31:0] ExMemData, MemWbData;
  logic [5:0]  Signal;
  logic [31:0] DataA, DataB, StoreData;
  logic [4:0]  WriteReg;
  logic        RegWrite, MemRead, MemWrite, MemToReg, IllegalOp;

  id_ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .IdRD1(IdRD1), .IdRD2(IdRD2), .IdImm(IdImm),
    .IdRs(IdRs), .IdRt(IdRt), .IdRd(IdRd), .IdShamt(IdShamt),
    .IdFunct(IdFunct), .IdALUOp(IdALUOp), .IdALUSrc(IdALUSrc),
    .IdRegDst(IdRegDst), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemData(ExMemData),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbData(MemWbData),
    .Signal(Signal), .DataA(DataA), .DataB(DataB), .StoreData(StoreData),
    .WriteReg(WriteReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .IllegalOp(IllegalOp)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  localparam logic [5:0] S_AND = 6'b100100, S_OR = 6'b100101, S_ADD = 6'b100000,
                         S_SUB = 6'b100010, S_SLT = 6'b101010, S_SRL = 6'b000010;

  // ctl = {RegWrite, MemRead, MemWrite, MemToReg, IllegalOp}
  typedef struct {
    string       name;
    int unsigned cyc;
    logic [5:0]  sig;
    logic [31:0] a, b, sd;
    logic [4:0]  wr;
    logic [4:0]  ctl;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic push(input string name, input logic [5:0] sig,
                      input logic [31:0] a, b, sd, input logic [4:0] wr, ctl);
    exp_t e;
    e.name = name; e.cyc = cyc; e.sig = sig;
    e.a = a; e.b = b; e.sd = sd; e.wr = wr; e.ctl = ctl;
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents one EX-stage result per cycle; compare at negedge.
  initial begin
    exp_t e;
    logic [4:0] act_ctl;
    forever begin
      @(negedge Clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        act_ctl = {RegWrite, MemRead, MemWrite, MemToReg, IllegalOp};
        checks++;
        if (e.cyc != cyc || Signal !== e.sig || DataA !== e.a || DataB !== e.b ||
            StoreData !== e.sd || WriteReg !== e.wr || act_ctl !== e.ctl) begin
          errors++;
          $display("FAIL %s: got sig=%b a=%h b=%h sd=%h wr=%0d ctl=%b, want sig=%b a=%h b=%h sd=%h wr=%0d ctl=%b (cyc %0d/%0d)",
                   e.name, Signal, DataA, DataB, StoreData, WriteReg, act_ctl,
                   e.sig, e.a, e.b, e.sd, e.wr, e.ctl, cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // ctl = {ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemToReg}
  task automatic set_id(input logic [31:0] rd1, rd2, imm,
                        input logic [4:0] rs, rt, rd, shamt,
                        input logic [5:0] funct, input logic [1:0] aluop,
                        input logic [5:0] ctl);
    IdRD1 = rd1; IdRD2 = rd2; IdImm = imm;
    IdRs = rs; IdRt = rt; IdRd = rd; IdShamt = shamt;
    IdFunct = funct; IdALUOp = aluop;
    {IdALUSrc, IdRegDst, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg} = ctl;
  endtask

  task automatic set_fwd(input logic exw, input logic [4:0] exrd, input logic [31:0] exd,
                         input logic wbw, input logic [4:0] wbrd, input logic [31:0] wbd);
    ExMemRegWrite = exw; ExMemRd = exrd; ExMemData = exd;
    MemWbRegWrite = wbw; MemWbRd = wbrd; MemWbData = wbd;
  endtask

  logic [31:0] exp_fa, exp_fb;

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    // Nonzero ID inputs while reset is held
    set_id(32'd9, 32'd4, 32'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100010, 2'b10, 6'b011000);
    tick();
    push("reset_out", S_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 5'b00000);
    Reset = 1'b0;
    tick();
    push("rtype_sub", S_SUB, 32'd9, 32'd4, 32'd4, 5'd3, 5'b10000);

    // Forwarding: rs=$5, rt=$6
    set_id(32'hAAAA, 32'hBBBB, 32'h0, 5'd5, 5'd6, 5'd7, 5'd0, 6'b100000, 2'b10, 6'b011000);
    tick();
    set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
`ifdef ID_EX_FORWARD_EN
    exp_fa = 32'h11;
`else
    exp_fa = 32'hAAAA;
`endif
    push("fwd_exmem_wins", S_ADD, exp_fa, 32'hBBBB, 32'hBBBB, 5'd7, 5'b10000);
    Stall = 1'b1;
    set_id(32'hDEAD, 32'hBEEF, 32'h1, 5'd21, 5'd22, 5'd23, 5'd3, 6'b100010, 2'b01, 6'b000110);
    tick();
    set_fwd(1'b1, 5'd9, 32'h44, 1'b1, 5'd6, 32'h33);
`ifdef ID_EX_FORWARD_EN
    exp_fb = 32'h33;
`else
    exp_fb = 32'hBBBB;
`endif
    push("fwd_memwb_rt", S_ADD, 32'hAAAA, exp_fb, exp_fb, 5'd7, 5'b10000);
    Stall = 1'b0;
    set_id(32'd5, 32'd6, 32'h0, 5'd0, 5'd0, 5'd1, 5'd0, 6'b100000, 2'b10, 6'b011000);
    tick();
    set_fwd(1'b1, 5'd0, 32'h77, 1'b1, 5'd0, 32'h88);
    push("fwd_reg0_never", S_ADD, 32'd5, 32'd6, 32'd6, 5'd1, 5'b10000);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // SRL and lw
    set_id(32'h1234, 32'h80000000, 32'h0, 5'd0, 5'd8, 5'd9, 5'd4, 6'b000010, 2'b10, 6'b011000);
    tick();
    push("srl", S_SRL, 32'h80000000, 32'd4, 32'h80000000, 5'd9, 5'b10000);
    set_id(32'h100, 32'h55, 32'hFFFFFFFC, 5'd2, 5'd10, 5'd0, 5'd0, 6'b101010, 2'b00, 6'b101101);
    tick();
    push("lw_imm", S_ADD, 32'h100, 32'hFFFFFFFC, 32'h55, 5'd10, 5'b11010);

    // ALUOp 11 with an unsupported funct: not R-type, so no illegal flag
    set_id(32'hF0, 32'h0F, 32'd4, 5'd3, 5'd4, 5'd0, 5'd0, 6'b000111, 2'b11, 6'b000010);
    tick();
    push("or_store", S_OR, 32'hF0, 32'h0F, 32'h0F, 5'd4, 5'b00100);

    // Stall two cycles with changing inputs
    Stall = 1'b1;
    set_id(32'h111, 32'h222, 32'h333, 5'd7, 5'd8, 5'd9, 5'd1, 6'b100100, 2'b10, 6'b111111);
    tick();
    push("stall_hold1", S_OR, 32'hF0, 32'h0F, 32'h0F, 5'd4, 5'b00100);
    set_id(32'h444, 32'h555, 32'h666, 5'd10, 5'd11, 5'd12, 5'd2, 6'b000010, 2'b10, 6'b011001);
    tick();
    push("stall_hold2", S_OR, 32'hF0, 32'h0F, 32'h0F, 5'd4, 5'b00100);
    Flush = 1'b1;
    tick();
    push("stall_flush_bubble", S_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 5'b00000);
    Flush = 1'b0; Stall = 1'b0;

    // Illegal funct, then a legal one clears the flag
    set_id(32'd3, 32'd5, 32'h0, 5'd11, 5'd12, 5'd13, 5'd0, 6'b000111, 2'b10, 6'b011000);
    tick();
    push("illegal_funct", S_ADD, 32'd3, 32'd5, 32'd5, 5'd13, 5'b10001);
    set_id(32'd1, 32'd2, 32'h0, 5'd14, 5'd15, 5'd16, 5'd0, 6'b101010, 2'b10, 6'b011000);
    tick();
    push("slt_after_illegal", S_SLT, 32'd1, 32'd2, 32'd2, 5'd16, 5'b10000);
    set_id(32'hFF00, 32'h0FF0, 32'h0, 5'd1, 5'd2, 5'd19, 5'd0, 6'b100100, 2'b10, 6'b011000);
    tick();
    push("and_rtype", S_AND, 32'hFF00, 32'h0FF0, 32'h0FF0, 5'd19, 5'b10000);
    set_id(32'd7, 32'd7, 32'h0, 5'd17, 5'd18, 5'd0, 5'd0, 6'b000000, 2'b01, 6'b000000);
    tick();
    push("beq_sub", S_SUB, 32'd7, 32'd7, 32'd7, 5'd18, 5'b00000);

    // Flush alone with live nonzero ID inputs
    Flush = 1'b1;
    tick();
    push("flush_bubble", S_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 5'b00000);
    Flush = 1'b0;

    // Reset mid-stream clears the held instruction immediately
    set_id(32'd1, 32'd2, 32'h0, 5'd3, 5'd20, 5'd0, 5'd0, 6'b000000, 2'b11, 6'b001000);
    tick();
    push("pre_reset", S_OR, 32'd1, 32'd2, 32'd2, 5'd20, 5'b10000);
    tick();
    Reset = 1'b1;
    push("reset_mid", S_ADD, 32'h0, 32'h0, 32'h0, 5'd0, 5'b00000);
    tick();
    Reset = 1'b0;
    tick();

    for (int w = 0; w < 10 && sb.size() > 0; w++) tick();
    if (sb.size() > 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
